ins_prefetch: RTL
=================

Name: ins_prefetch

Overview:
- Instruction prefetch queue feeding the execution controller.
- Issues long-word (32-bit) reads to local instruction memory and splits each long into two 16-bit instruction words, big-endian (high half first).
- Buffers the words in a small FIFO and presents the head word with insrdy.
- Pops the head word when the execution controller pulses romold; this also covers the immediate-data words consumed after an immld instruction.
- A jump (pc_ld) flushes the queue and restarts fetching at a new address.

Parameters:
- DEPTH, 8, queue capacity in 16-bit words; power of two, minimum 4.
- AW, 24, byte address width of fetch_addr, pc_in and pc_out.

Ports:
- clk_0  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- go  input  1  fetch enable; when low no new request is issued (an outstanding one completes).
- pc_ld  input  1  jump strobe; one-cycle pulse.
- pc_in  input  AW  jump target; bit 0 ignored (forced 0).
- fetch_req  output  1  memory read request.
- fetch_addr  output  AW  long-aligned read address; bits 1:0 always 0.
- fetch_ack  input  1  read complete; fetch_data valid this cycle.
- fetch_data  input  32  read data; [31:16] is the lower-addressed word.
- ins_out  output  16  head instruction word.
- insrdy  output  1  ins_out valid (queue not empty).
- romold  input  1  pop head word this cycle.
- pc_out  output  AW  byte address of ins_out.

Behaviour:
Reset:
- fetch_req=0, fetch_addr=0, insrdy=0, ins_out=0, pc_out=0.
- Queue empty; discard flag clear; fetch pointer = 0.

State machine (FSM): IDLE, REQ.
- IDLE -> REQ when go=1 and free slots >= 2. fetch_req rises next edge; fetch_addr = fetch pointer with bits 1:0 cleared.
- REQ holds fetch_req and fetch_addr stable until fetch_ack.
- On the fetch_ack cycle: REQ -> IDLE and fetch pointer += 4.
- A new request can issue on the cycle after ack. One request outstanding maximum.

Queue write (on fetch_ack, discard clear):
- Normally push fetch_data[31:16] then [15:0] (2 entries).
- First fetch after pc_ld with target bit 1 = 1: push only [15:0] (1 entry).
- The free-slots >= 2 rule guarantees no overflow.

Queue read:
- insrdy = count != 0; ins_out = head entry (registered storage, no bypass).
- romold=1 with insrdy=1: pop; pc_out += 2.
- romold with insrdy=0: ignored; pc_out unchanged.
- Push and pop in the same cycle: count += pushed - 1.
- Pointer and count arithmetic wraps modulo DEPTH; count is log2(DEPTH)+1 bits.

Latency:
- ack at cycle N -> insrdy=1 and ins_out valid at N+1.
- Empty queue, go=1: fetch_req at the first edge.

Jump (pc_ld):
- On the edge: queue emptied, insrdy=0 next cycle.
- pc_out = {pc_in[AW-1:1],0}; fetch pointer = {pc_in[AW-1:2],00}; misalign flag = pc_in[1].
- If in REQ: fetch_req held until ack (the bus request is never withdrawn), discard set; the returning data is dropped, then discard clears; the next request uses the new pointer.
- If in IDLE: a request to the new target issues on the following edge.

Priority and simultaneous events:
- pc_ld and romold together: pc_ld wins, the pop is ignored.
- pc_ld and fetch_ack together: the data is dropped, discard stays clear, and the new request may issue next edge.
- go falling during REQ: the outstanding fetch completes and its data is stored.
- Reset mid-REQ: fetch_req drops immediately (asynchronous); a late ack is ignored since state is IDLE.

Test Plan:
1. Reset release, go=1, memory returns 0x12345678 at addr 0 with ack 2 cycles after req -> fetch_addr=0; next cycle insrdy=1, ins_out=0x1234, pc_out=0; romold -> ins_out=0x5678, pc_out=2.
2. No pops, DEPTH=8, ack every request -> exactly 4 fetches (addr 0,4,8,C), fetch_req stays 0 with count=8; one pop leaves free=1, still no request; second pop -> request to 0x10.
3. pc_ld with pc_in=0x000102 while idle -> fetch_addr=0x000100; ack data 0xAAAABBBB -> only 0xBBBB queued, pc_out=0x102; next fetch 0x104.
4. pc_ld to 0x200 while a request to 0x40 is outstanding -> fetch_req held, ack data dropped (insrdy stays 0), then fetch_addr=0x200, ins_out from 0x200.
5. Continuous romold at one word per cycle with single-cycle ack memory -> no spurious pops when insrdy=0; pc_out sequence matches the popped words exactly; count never exceeds DEPTH.
6. reset_n asserted while fetch_req=1 -> all outputs 0 immediately; an ack arriving after reset release produces no queue write.

Source files
------------

// File: rtl/ins_prefetch.sv
// Instruction prefetch queue: fetches 32-bit longs, splits them into
// big-endian 16-bit words and hands them to the execution controller.
module ins_prefetch #(
   parameter int DEPTH = 8,
   parameter int AW    = 24
) (
   input  logic          clk_0,
   input  logic          reset_n,
   input  logic          go,
   input  logic          pc_ld,
   input  logic [AW-1:0] pc_in,
   output logic          fetch_req,
   output logic [AW-1:0] fetch_addr,
   input  logic          fetch_ack,
   input  logic [31:0]   fetch_data,
   output logic [15:0]   ins_out,
   output logic          insrdy,
   input  logic          romold,
   output logic [AW-1:0] pc_out
);

   localparam int LW = $clog2(DEPTH);
   localparam logic [LW:0] CNT_LIM = (LW+1)'(DEPTH - 2);

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state_q, state_d;
   logic          fetch_req_q, fetch_req_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] fptr_q, fptr_d;
   logic          misal_q, misal_d;
   logic          discard_q, discard_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [LW-1:0] wr_q, wr_d;
   logic [LW-1:0] rd_q, rd_d;
   logic [LW:0]   cnt_q, cnt_d;
   logic [15:0]   mem_q [DEPTH];
   logic [15:0]   mem_d [DEPTH];

   logic can_issue;
   logic pop;
   logic keep;
   logic push1;
   logic push2;

   assign can_issue = go && !pc_ld && (cnt_q <= CNT_LIM);
   assign pop       = romold && (cnt_q != '0) && !pc_ld;
   assign keep      = fetch_ack && (state_q == REQ)
                      && !discard_q && !pc_ld;
   assign push2     = keep && !misal_q;
   assign push1     = keep && misal_q;

   always_comb begin
      state_d     = state_q;
      fetch_req_d = fetch_req_q;
      addr_d      = addr_q;
      fptr_d      = fptr_q;
      misal_d     = misal_q;
      discard_d   = discard_q;
      pc_d        = pc_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      mem_d       = mem_q;
      cnt_d       = cnt_q
                    + {{(LW-1){1'b0}}, push2, push1}
                    - {{LW{1'b0}}, pop};

      unique case (state_q)
         IDLE: begin
            if (can_issue) begin
               state_d     = REQ;
               fetch_req_d = 1'b1;
               addr_d      = {fptr_q[AW-1:2], 2'b00};
            end
         end
         REQ: begin
            if (fetch_ack) begin
               state_d     = IDLE;
               fetch_req_d = 1'b0;
               discard_d   = 1'b0;
               if (!discard_q) fptr_d = fptr_q + AW'(4);
            end
         end
         default: ;
      endcase

      if (push2) begin
         mem_d[wr_q]          = fetch_data[31:16];
         mem_d[wr_q + LW'(1)] = fetch_data[15:0];
         wr_d                 = wr_q + LW'(2);
      end else if (push1) begin
         mem_d[wr_q] = fetch_data[15:0];
         wr_d        = wr_q + LW'(1);
      end
      if (keep) misal_d = 1'b0;

      if (pop) begin
         rd_d = rd_q + LW'(1);
         pc_d = pc_q + AW'(2);
      end

      // A jump mid-request cannot withdraw the bus cycle, so its data is dropped
      if (pc_ld) begin
         fptr_d    = {pc_in[AW-1:2], 2'b00};
         misal_d   = pc_in[1];
         pc_d      = {pc_in[AW-1:1], 1'b0};
         discard_d = (state_q == REQ) && !fetch_ack;
         wr_d      = '0;
         rd_d      = '0;
         cnt_d     = '0;
      end
   end

   always_ff @(posedge clk_0 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         fetch_req_q <= 1'b0;
         addr_q      <= '0;
         fptr_q      <= '0;
         misal_q     <= 1'b0;
         discard_q   <= 1'b0;
         pc_q        <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         fetch_req_q <= fetch_req_d;
         addr_q      <= addr_d;
         fptr_q      <= fptr_d;
         misal_q     <= misal_d;
         discard_q   <= discard_d;
         pc_q        <= pc_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
      end
   end

   assign fetch_req  = fetch_req_q;
   assign fetch_addr = addr_q;
   assign ins_out    = mem_q[rd_q];
   assign insrdy     = (cnt_q != '0);
   assign pc_out     = pc_q;

endmodule
